dly_tap_ctrl: RTL and testbench

- Per-channel delay tap register bank and adjust controller.
- Holds NUM_TAPS independent tap values and applies load and increment/decrement commands addressed by DLY_ADDR.
- Drives the packed tap value bus consumed by the downstream tap-value multiplexer; each channel slice feeds one DLY_TAPn_VAL input.
- Enforces a settle window after every update, during which new commands are refused.

---
 rtl/dly_tap_ctrl_if.sv | 26 ++
 rtl/dly_tap_ctrl.sv | 103 ++++++++++
 tb/tb_dly_tap_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dly_tap_ctrl_if.sv
// Command/status bundle for the delay tap controller. The packed tap bus feeds the
// downstream tap-value multiplexer, one TAP_W slice per channel.
interface dly_tap_ctrl_if #(
  parameter int NUM_TAPS = 20,
  parameter int TAP_W    = 6
);
  logic [4:0]                DLY_ADDR;
  logic                      DLY_LOAD;
  logic [TAP_W-1:0]          DLY_LOAD_VAL;
  logic                      DLY_ADJ;
  logic                      DLY_INCDEC;
  logic [NUM_TAPS*TAP_W-1:0] DLY_TAP_VAL_BUS;
  logic                      DLY_BUSY;
  logic                      CMD_DROP;
  logic                      ADDR_ERR;

  modport master (
    output DLY_ADDR, DLY_LOAD, DLY_LOAD_VAL, DLY_ADJ, DLY_INCDEC,
    input  DLY_TAP_VAL_BUS, DLY_BUSY, CMD_DROP, ADDR_ERR
  );

  modport slave (
    input  DLY_ADDR, DLY_LOAD, DLY_LOAD_VAL, DLY_ADJ, DLY_INCDEC,
    output DLY_TAP_VAL_BUS, DLY_BUSY, CMD_DROP, ADDR_ERR
  );
endinterface

// File: rtl/dly_tap_ctrl.sv
// Per-channel delay tap register bank with load/adjust commands and a settle window.
// Define DLY_TAP_WRAP_EN to make adjusts wrap modulo 2^TAP_W instead of saturating.
module dly_tap_ctrl #(
  parameter int NUM_TAPS      = 20,
  parameter int TAP_W         = 6,
  parameter int INIT_TAP      = 0,
  parameter int SETTLE_CYCLES = 4
) (
  input logic         CLK,
  input logic         RST,
  dly_tap_ctrl_if.slave bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TAP_W-1:0] TAP_MAX = '1;

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAP_W-1:0] tap_q [NUM_TAPS];
  logic [TAP_W-1:0] tap_d [NUM_TAPS];
  logic             load_q, adj_q;
  logic             drop_q, drop_d;
  logic             err_q, err_d;
  logic             load_edge, adj_edge, cmd_edge, addr_ok;

  function automatic logic [TAP_W-1:0] adjust_tap(input logic [TAP_W-1:0] v, input logic inc);
`ifdef DLY_TAP_WRAP_EN
    adjust_tap = inc ? v + 1'b1 : v - 1'b1;
`else
    if (inc) adjust_tap = (v == TAP_MAX) ? v : v + 1'b1;
    else     adjust_tap = (v == '0)      ? v : v - 1'b1;
`endif
  endfunction

  assign load_edge = bus.DLY_LOAD & ~load_q;
  assign adj_edge  = bus.DLY_ADJ  & ~adj_q;
  assign cmd_edge  = load_edge | adj_edge;
  assign addr_ok   = {1'b0, bus.DLY_ADDR} < 6'(NUM_TAPS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    drop_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_edge) begin
          if (addr_ok) begin
            // A simultaneous adjust edge is swallowed by the load.
            for (int n = 0; n < NUM_TAPS; n++) begin
              if (bus.DLY_ADDR == 5'(n))
                tap_d[n] = load_edge ? bus.DLY_LOAD_VAL : adjust_tap(tap_q[n], bus.DLY_INCDEC);
            end
            if (SETTLE_CYCLES > 0) begin
              state_d = SETTLE;
              cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cmd_edge) drop_d = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      adj_q   <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int n = 0; n < NUM_TAPS; n++) tap_q[n] <= TAP_W'(INIT_TAP);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= bus.DLY_LOAD;
      adj_q   <= bus.DLY_ADJ;
      drop_q  <= drop_d;
      err_q   <= err_d;
      tap_q   <= tap_d;
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_pack
    assign bus.DLY_TAP_VAL_BUS[g*TAP_W +: TAP_W] = tap_q[g];
  end

  assign bus.DLY_BUSY = (state_q == SETTLE);
  assign bus.CMD_DROP = drop_q;
  assign bus.ADDR_ERR = err_q;

endmodule

// File: tb/tb_dly_tap_ctrl.sv
// Scoreboarded bench for dly_tap_ctrl: directed scenarios followed by random commands,
// checked against an array-based model of the tap bank and settle window.
module tb_dly_tap_ctrl;

  localparam int NT     = 20;
  localparam int TW     = 6;
  localparam int INIT   = 0;
  localparam int SETTLE = 4;
  localparam int MAXV   = (1 << TW) - 1;

  typedef struct {
    logic [NT*TW-1:0] taps;
    logic             busy;
    logic             drop;
    logic             err;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  dly_tap_ctrl_if #(.NUM_TAPS(NT), .TAP_W(TW)) bus ();

  dly_tap_ctrl #(
    .NUM_TAPS(NT), .TAP_W(TW), .INIT_TAP(INIT), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int   mtap[NT];
  int   busy_rem;
  bit   prev_ld, prev_aj;

  task automatic check_vec(input string tag, input exp_t e);
    bit bad;
    bad = 0;
    n_vec++;
    if (bus.DLY_TAP_VAL_BUS !== e.taps) begin
      $display("FAIL %s taps: got %h want %h", tag, bus.DLY_TAP_VAL_BUS, e.taps); bad = 1;
    end
    if (bus.DLY_BUSY !== e.busy) begin
      $display("FAIL %s busy: got %b want %b", tag, bus.DLY_BUSY, e.busy); bad = 1;
    end
    if (bus.CMD_DROP !== e.drop) begin
      $display("FAIL %s cmd_drop: got %b want %b", tag, bus.CMD_DROP, e.drop); bad = 1;
    end
    if (bus.ADDR_ERR !== e.err) begin
      $display("FAIL %s addr_err: got %b want %b", tag, bus.ADDR_ERR, e.err); bad = 1;
    end
    if (bad) n_bad++;
  endtask

  function automatic logic [NT*TW-1:0] pack_model();
    logic [NT*TW-1:0] v;
    v = '0;
    for (int n = 0; n < NT; n++) v[n*TW +: TW] = TW'(mtap[n]);
    return v;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NT; n++) mtap[n] = INIT;
    busy_rem = 0;
    prev_ld  = 0;
    prev_aj  = 0;
  endtask

  task automatic model_step(input bit ld, input bit aj, input bit inc, input int addr, input int val);
    bit   le, ae;
    exp_t e;
    le = ld && !prev_ld;
    ae = aj && !prev_aj;
    prev_ld = ld;
    prev_aj = aj;
    e.drop = 0;
    e.err  = 0;
    if (busy_rem > 0) begin
      if (le || ae) e.drop = 1;
      busy_rem--;
    end else if (le || ae) begin
      if (addr < NT) begin
        if (le) mtap[addr] = val;
`ifdef DLY_TAP_WRAP_EN
        else if (inc) mtap[addr] = (mtap[addr] + 1) % (MAXV + 1);
        else          mtap[addr] = (mtap[addr] + MAXV) % (MAXV + 1);
`else
        else if (inc) mtap[addr] = (mtap[addr] == MAXV) ? MAXV : mtap[addr] + 1;
        else          mtap[addr] = (mtap[addr] == 0) ? 0 : mtap[addr] - 1;
`endif
        busy_rem = SETTLE;
      end else begin
        e.err = 1;
      end
    end
    e.busy = (busy_rem > 0);
    e.taps = pack_model();
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: inputs change 2 time units after the edge.
  task automatic cyc(input bit ld, input bit aj, input bit inc, input int addr, input int val);
    @(posedge CLK);
    #2;
    bus.DLY_LOAD     = ld;
    bus.DLY_ADJ      = aj;
    bus.DLY_INCDEC   = inc;
    bus.DLY_ADDR     = 5'(addr);
    bus.DLY_LOAD_VAL = TW'(val);
    model_step(ld, aj, inc, addr, val);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected response per clock edge, sampled 1 unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_vec("cycle", e);
      end
    end
  end

  initial begin
    exp_t e;
    bus.DLY_LOAD = 0; bus.DLY_ADJ = 0; bus.DLY_INCDEC = 0;
    bus.DLY_ADDR = '0; bus.DLY_LOAD_VAL = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;

    idle(2);
    // Load channel 5, then watch the settle window.
    cyc(1, 0, 0, 5, 33);
    cyc(0, 0, 0, 5, 33);
    idle(5);
    // Held adjust level yields a single increment.
    cyc(1, 0, 0, 2, 7);
    cyc(0, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 2, 0);
    cyc(0, 0, 0, 2, 0);
    idle(5);
    // Saturation (or wrap) at both ends.
    cyc(1, 0, 0, 19, 63);
    idle(5);
    cyc(0, 1, 1, 19, 0);
    idle(5);
    cyc(0, 1, 0, 0, 0);
    idle(5);
    // Adjust during settle is dropped, then accepted once idle.
    cyc(1, 0, 0, 1, 10);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 3, 0);
    cyc(0, 0, 0, 3, 0);
    idle(4);
    cyc(0, 1, 1, 3, 0);
    cyc(0, 0, 0, 3, 0);
    idle(5);
    // Out-of-range address, then simultaneous load+adjust.
    cyc(1, 0, 0, 25, 44);
    cyc(0, 0, 0, 25, 0);
    idle(2);
    cyc(1, 1, 1, 4, 20);
    cyc(0, 0, 0, 4, 0);
    idle(5);
    // Out-of-range address while busy reports a drop only.
    cyc(1, 0, 0, 6, 12);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 30, 1);
    cyc(0, 0, 0, 0, 0);
    idle(4);

    // Asynchronous reset during the second settle cycle.
    cyc(1, 0, 0, 7, 45);
    cyc(0, 0, 0, 7, 0);
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    model_reset();
    e.taps = pack_model();
    e.busy = 0; e.drop = 0; e.err = 0;
    check_vec("async_rst", e);
    @(posedge CLK);
    #2 RST = 1'b0;
    idle(2);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, NT - 1)),
          int'($urandom_range(0, MAXV)));
    end
    idle(3);
    @(posedge CLK);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
